// File: rtl/sprite_palette_arbiter.sv
// Round-robin arbiter: four sprite requesters share one palette lookup; optional TRANSPARENT_SKIP_EN drops index-0 results.
// Latency: one cycle from sampled req to grant/out_valid. Backpressure: out_ready=0 holds the result and stalls captures.
module sprite_palette_arbiter (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  req,
  input  logic [15:0] idx,
  output logic [3:0]  grant,
  output logic [3:0]  pal_index,
  input  logic [3:0]  pal_red,
  input  logic [3:0]  pal_green,
  input  logic [3:0]  pal_blue,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_id,
  output logic [3:0]  red,
  output logic [3:0]  green,
  output logic [3:0]  blue
);

  typedef enum logic {IDLE, OUT} state_t;

  state_t      state_q, state_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  pal_index_q, pal_index_d;
  logic [1:0]  out_id_q, out_id_d;
  logic [1:0]  last_q, last_d;

  logic [3:0]  elig;
  logic [1:0]  cand;
  logic [1:0]  winner;
  logic        found;
  logic        capture;
  logic        skip;
  logic [3:0]  win_idx;

  // A requester whose grant is visible this cycle still holds req high; mask it.
  assign elig = req & ~grant_q;

  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!found && elig[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign win_idx = idx[{winner, 2'b00} +: 4];

`ifdef TRANSPARENT_SKIP_EN
  assign skip = (win_idx == 4'd0);
`else
  assign skip = 1'b0;
`endif

  assign capture = found && ((state_q == IDLE) || out_ready);

  always_comb begin
    state_d     = state_q;
    grant_d     = 4'b0000;
    pal_index_d = pal_index_q;
    out_id_d    = out_id_q;
    last_d      = last_q;
    if (capture) begin
      grant_d     = 4'b0001 << winner;
      pal_index_d = win_idx;
      out_id_d    = winner;
      last_d      = winner;
      state_d     = skip ? IDLE : OUT;
    end else if ((state_q == OUT) && out_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= IDLE;
      grant_q     <= 4'b0000;
      pal_index_q <= 4'd0;
      out_id_q    <= 2'd0;
      last_q      <= 2'd3;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      pal_index_q <= pal_index_d;
      out_id_q    <= out_id_d;
      last_q      <= last_d;
    end
  end

  assign grant     = grant_q;
  assign pal_index = pal_index_q;
  assign out_id    = out_id_q;
  assign out_valid = (state_q == OUT);
  assign red       = out_valid ? pal_red   : 4'd0;
  assign green     = out_valid ? pal_green : 4'd0;
  assign blue      = out_valid ? pal_blue  : 4'd0;

endmodule

// File: doc/sprite_palette_arbiter.md
SPRITE_PALETTE_ARBITER -- requirements
Module: sprite_palette_arbiter

Interface
REQ-001 The block SHALL use a single clock and a reset that is synchronous and active-high.
REQ-002 Port: Clk  input  1  system clock; all state updates on the rising edge.
REQ-003 Port: Reset  input  1  synchronous, active-high reset.
REQ-004 Port: req  input  4  per-requester request; bit n is requester n; held high until that requester's grant is seen.
REQ-005 Port: idx  input  16  packed 4-bit palette indices; idx[4n+3:4n] belongs to requester n and is valid while req[n] is high.
REQ-006 Port: grant  output  4  one-hot; pulses for exactly one cycle when that requester's index is captured.
REQ-007 Port: pal_index  output  4  registered index driven to the shared external palette lookup.
REQ-008 Port: pal_red, pal_green, pal_blue  input  4 each  combinational colour returned by the palette for pal_index.
REQ-009 Port: out_valid  output  1  result available.
REQ-010 Port: out_ready  input  1  consumer accepts the result this cycle.
REQ-011 Port: out_id  output  2  requester number that owns the current result.
REQ-012 Port: red, green, blue  output  4 each  result colour; equal to pal_* while out_valid is high, 0 otherwise.

Function
REQ-013 FSM states SHALL be IDLE (no result held) and OUT (result held, out_valid=1).
REQ-014 Eligible set SHALL be req with the bit of any requester whose grant is high in the current cycle masked off.
REQ-015 Winner SHALL be chosen round-robin: search starts at (last_grant+1) mod 4 and wraps; last_grant updates on every capture.
REQ-016 Capture SHALL happen at an edge where the eligible set is non-empty and the state is IDLE, or the state is OUT with out_ready=1.
REQ-017 On capture: pal_index <= winner's idx; out_id <= winner; grant <= one-hot(winner) for the next cycle only; next state = OUT.
REQ-018 Latency SHALL be one cycle: a request sampled at edge T gives grant and out_valid high during cycle T+1.
REQ-019 In OUT with out_ready=0: pal_index, out_id and the colour outputs SHALL hold, no grant SHALL be issued, and pending requests SHALL wait.
REQ-020 In OUT with out_ready=1 and an empty eligible set: next state = IDLE; out_valid=0 from the next cycle.
REQ-021 Back-to-back throughput SHALL be one result per cycle while out_ready stays 1 and requests are pending.
REQ-022 If all four requesters are continuously requesting, grants SHALL rotate 0,1,2,3,0...; no requester waits more than 3 captures.
REQ-023 A req bit deasserted before its grant SHALL simply be dropped, with no error and no grant.
REQ-024 grant SHALL be all-zero in every cycle without a capture.

Reset
REQ-025 Reset SHALL force: state IDLE, grant 0, out_valid 0, out_id 0, pal_index 0, red/green/blue 0, and last_grant 3 (requester 0 has first priority).
REQ-026 Reset asserted mid-transaction SHALL discard the held result with no grant issued; arbitration resumes on the first edge after Reset falls.

Configuration
REQ-027 Macro TRANSPARENT_SKIP_EN: when defined, a captured index of 0 (transparent) SHALL still pulse grant but SHALL NOT raise out_valid.
REQ-028 With TRANSPARENT_SKIP_EN defined, a skipped capture SHALL still update last_grant, and the next state SHALL be IDLE unless another capture occurs.
REQ-029 With TRANSPARENT_SKIP_EN undefined, index 0 SHALL be treated like any other index.

Verification
REQ-030 Reset held 2 cycles with req=4'hF -> grant=0, out_valid=0 and all outputs 0 throughout; first grant after release = 4'b0001.
REQ-031 req=4'b0100, idx[11:8]=4'h9, out_ready=1 -> the next cycle has grant=4'b0100, out_valid=1, out_id=2, pal_index=9, and red/green/blue equal to pal_*.
REQ-032 req=4'hF held with out_ready=1 -> grants 0001, 0010, 0100, 1000, 0001 on consecutive cycles, with out_valid continuously 1.
REQ-033 In OUT, out_ready=0 for 5 cycles while req=4'b0011 -> outputs stable and grant=0 for 5 cycles; the next grant follows out_ready=1.
REQ-034 With TRANSPARENT_SKIP_EN, req=4'b0001 and idx=0 -> grant=4'b0001 for one cycle, out_valid stays 0, and the state returns to IDLE.
REQ-035 Reset asserted in OUT while out_ready=0 -> out_valid=0 on the next cycle and no grant is issued for the discarded result.
